// File: rtl/hex_input_reg_pkg.sv
// Shared constants and helpers for the hex entry register: digit geometry,
// debounce default and the lowest-set-bit encoder used to pick one digit.
package hex_input_reg_pkg;

   localparam int DB_CYCLES_DEFAULT = 1_000_000;
   localparam int NDIGITS           = 8;
   localparam int DIGIT_W           = 4;
   localparam int WORD_W            = NDIGITS * DIGIT_W;
   localparam int CNT_W             = 4;
   localparam int NSW               = 16;

   // Scanning downward lets the lowest set index overwrite any higher one.
   function automatic logic [DIGIT_W-1:0] lowestIndex(input logic [NSW-1:0] vec);
      logic [DIGIT_W-1:0] idx;
      idx = '0;
      for (int i = NSW - 1; i >= 0; i--) begin
         if (vec[i]) idx = DIGIT_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/hex_input_reg_debouncer.sv
// Two-flop synchronizer followed by a stable-run debouncer; rise/fall pulse
// in the single cycle the debounced level takes its new value.
module debouncer
   import hex_input_reg_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rstn,
   input  logic in,
   output logic out,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] count_q, count_d;

   // Count consecutive cycles of disagreement; any agreement restarts the run.
   always_comb begin
      count_d = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (count_q == CW'(DB_CYCLES - 1)) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
         end else begin
            count_d = count_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         count_q <= '0;
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         count_q <= count_d;
      end
   end

   assign out  = level_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/hex_input_reg.sv
// Hex entry register: debounced switches shift digits in, buttons delete or
// clear, with clear > delete > lowest-index digit when events coincide.
module hex_input_reg
   import hex_input_reg_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NSW-1:0]    sw,
   input  logic              btn_del,
   input  logic              btn_clr,
   output logic [WORD_W-1:0] d,
   output logic [CNT_W-1:0]  cnt,
   output logic              upd
);

   localparam int NIN = NSW + 2;

   logic [NIN-1:0]    rawIn;
   logic [NIN-1:0]    level;
   logic [NIN-1:0]    riseEv;
   logic [NIN-1:0]    fallEv;
   logic [NSW-1:0]    digitEv;
   logic              delEv, clrEv;
   logic              unusedBits;
   logic [WORD_W-1:0] d_q, d_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              upd_q, upd_d;

   assign rawIn = {btn_clr, btn_del, sw};

   for (genvar g = 0; g < NIN; g++) begin : gDeb
      debouncer #(.DB_CYCLES(DB_CYCLES)) uDeb (
         .clk  (clk),
         .rstn (rstn),
         .in   (rawIn[g]),
         .out  (level[g]),
         .rise (riseEv[g]),
         .fall (fallEv[g])
      );
   end

   // Switches act on either edge; buttons only on press.
   assign digitEv    = riseEv[NSW-1:0] | fallEv[NSW-1:0];
   assign delEv      = riseEv[NSW];
   assign clrEv      = riseEv[NSW+1];
   assign unusedBits = ^{level, fallEv[NIN-1:NSW]};

   always_comb begin
      d_d   = d_q;
      cnt_d = cnt_q;
      upd_d = 1'b0;
      if (clrEv) begin
         d_d   = '0;
         cnt_d = '0;
         upd_d = 1'b1;
      end else if (delEv) begin
         d_d   = {{DIGIT_W{1'b0}}, d_q[WORD_W-1:DIGIT_W]};
         cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
         upd_d = 1'b1;
      end else if (|digitEv) begin
         d_d   = {d_q[WORD_W-DIGIT_W-1:0], lowestIndex(digitEv)};
         cnt_d = (cnt_q == CNT_W'(NDIGITS)) ? cnt_q : cnt_q + CNT_W'(1);
         upd_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         d_q   <= '0;
         cnt_q <= '0;
         upd_q <= 1'b0;
      end else begin
         d_q   <= d_d;
         cnt_q <= cnt_d;
         upd_q <= upd_d;
      end
   end

   assign d   = d_q;
   assign cnt = cnt_q;
   assign upd = upd_q;

endmodule

// File: tb/tb_hex_input_reg.sv
// Scoreboard bench for hex_input_reg with a short debounce: each driven input
// change predicts the resulting word/count, checked whenever upd pulses.
module tb_hex_input_reg;

   localparam int DB   = 4;
   localparam int HOLD = 14;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] sw = '0;
   logic        btn_del = 1'b0;
   logic        btn_clr = 1'b0;
   logic [31:0] d;
   logic [3:0]  cnt;
   logic        upd;

   int checks = 0;
   int errors = 0;
   int updCount = 0;

   logic [35:0] sbQ[$];
   logic [31:0] modelD = '0;
   logic [3:0]  modelCnt = '0;

   hex_input_reg #(.DB_CYCLES(DB)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .sw      (sw),
      .btn_del (btn_del),
      .btn_clr (btn_clr),
      .d       (d),
      .cnt     (cnt),
      .upd     (upd)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Every upd pulse must match the oldest outstanding prediction.
   always @(negedge clk) begin
      if (rstn === 1'b1 && upd === 1'b1) begin
         updCount++;
         if (sbQ.size() == 0) begin
            checkOutput("spuriousUpd", 32'd1, 32'd0);
         end else begin
            logic [35:0] exp;
            exp = sbQ.pop_front();
            checkOutput("sbD", d, exp[35:4]);
            checkOutput("sbCnt", {28'd0, cnt}, {28'd0, exp[3:0]});
         end
      end
   end

   task automatic applyStimulus(input logic [15:0] newSw, input logic newDel, input logic newClr);
      logic [15:0] changed;
      logic [3:0]  idx;
      @(negedge clk);
      changed = sw ^ newSw;
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (changed[i]) idx = 4'(i);
      end
      if (newClr && !btn_clr) begin
         modelD = '0;
         modelCnt = '0;
         sbQ.push_back({modelD, modelCnt});
      end else if (newDel && !btn_del) begin
         modelD = {4'h0, modelD[31:4]};
         if (modelCnt != 0) modelCnt = modelCnt - 4'd1;
         sbQ.push_back({modelD, modelCnt});
      end else if (changed != 0) begin
         modelD = {modelD[27:0], idx};
         if (modelCnt < 4'd8) modelCnt = modelCnt + 4'd1;
         sbQ.push_back({modelD, modelCnt});
      end
      sw = newSw;
      btn_del = newDel;
      btn_clr = newClr;
      repeat (HOLD) @(negedge clk);
      checkOutput("drain", sbQ.size(), 32'd0);
      sbQ.delete();
   endtask

   task automatic checkState(input string tag, input logic [31:0] expD, input logic [3:0] expCnt);
      checkOutput({tag, "D"}, d, expD);
      checkOutput({tag, "Cnt"}, {28'd0, cnt}, {28'd0, expCnt});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int updBefore;
      repeat (3) @(negedge clk);
      checkState("reset", 32'h0, 4'd0);
      checkOutput("resetUpd", {31'd0, upd}, 32'd0);
      rstn = 1'b1;
      repeat (HOLD) @(negedge clk);
      checkOutput("idleUpd", updCount, 32'd0);

      applyStimulus(16'h0008, 1'b0, 1'b0);
      applyStimulus(16'h0408, 1'b0, 1'b0);
      checkState("twoDigits", 32'h0000_003A, 4'd2);

      applyStimulus(sw, 1'b0, 1'b1);
      applyStimulus(sw, 1'b0, 1'b0);
      checkState("clear", 32'h0, 4'd0);

      for (int k = 0; k < 9; k++) applyStimulus(sw ^ 16'h0002, 1'b0, 1'b0);
      checkState("saturate", 32'h1111_1111, 4'd8);

      applyStimulus(sw, 1'b0, 1'b1);
      applyStimulus(sw, 1'b0, 1'b0);
      applyStimulus(sw ^ 16'h0400, 1'b0, 1'b0);
      applyStimulus(sw ^ 16'h0800, 1'b0, 1'b0);
      applyStimulus(sw ^ 16'h1000, 1'b0, 1'b0);
      checkState("abc", 32'h0000_0ABC, 4'd3);

      for (int k = 0; k < 4; k++) begin
         applyStimulus(sw, 1'b1, 1'b0);
         applyStimulus(sw, 1'b0, 1'b0);
         if (k == 2) checkState("delEmpty", 32'h0, 4'd0);
      end
      checkState("delNoop", 32'h0, 4'd0);

      updBefore = updCount;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         sw[5] = 1'b1;
         repeat (2) @(negedge clk);
         sw[5] = 1'b0;
         repeat (2) @(negedge clk);
      end
      repeat (HOLD) @(negedge clk);
      checkOutput("glitchUpd", updCount - updBefore, 32'd0);
      checkState("glitch", 32'h0, 4'd0);

      applyStimulus(sw ^ 16'h8000, 1'b0, 1'b0);
      applyStimulus(sw ^ 16'h8000, 1'b0, 1'b0);
      checkState("ff", 32'h0000_00FF, 4'd2);
      applyStimulus(sw ^ 16'h0084, 1'b0, 1'b1);
      applyStimulus(sw, 1'b0, 1'b0);
      checkState("clrWins", 32'h0, 4'd0);

      applyStimulus(sw ^ 16'h8000, 1'b0, 1'b0);
      applyStimulus(sw ^ 16'h8000, 1'b0, 1'b0);
      applyStimulus(sw ^ 16'h0084, 1'b0, 1'b0);
      checkState("lowestWins", 32'h0000_0FF2, 4'd3);

      applyStimulus(16'h0000, 1'b0, 1'b0);

      // Reset lands two cycles into the debounce of sw[4].
      @(negedge clk);
      sw[4] = 1'b1;
      repeat (4) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      checkState("midReset", 32'h0, 4'd0);
      checkOutput("midResetUpd", {31'd0, upd}, 32'd0);
      sbQ.delete();
      modelD = '0;
      modelCnt = '0;
      repeat (3) @(negedge clk);
      modelD = 32'h4;
      modelCnt = 4'd1;
      sbQ.push_back({modelD, modelCnt});
      rstn = 1'b1;
      repeat (HOLD) @(negedge clk);
      checkOutput("drainAfterReset", sbQ.size(), 32'd0);
      checkState("afterReset", 32'h0000_0004, 4'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
